// File: rtl/ac_match_ctrl.sv
// ac_match_ctrl: Aho-Corasick matching controller that walks an external goto/failure/output table
// one character at a time and reports the resulting state, match flag and position.
module ac_match_ctrl #(
   parameter int NENT = 32,
   parameter int SW = 8,
   parameter int CW = 4,
   localparam int AW = $clog2(NENT),
   localparam int TW = (AW > SW) ? AW : SW
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          EN,
   input  logic          FLUSH,
   input  logic          CH_VALID,
   input  logic [CW-1:0] CH_DATA,
   output logic          CH_READY,
   output logic          TBL_RD,
   output logic          TBL_SEL,
   output logic [TW-1:0] TBL_ADDR,
   input  logic [SW-1:0] TBL_CUR,
   input  logic [CW-1:0] TBL_CHR,
   input  logic [SW-1:0] TBL_NXT,
   input  logic [SW-1:0] TBL_FAIL,
   input  logic          TBL_OUT,
   output logic          RES_VALID,
   output logic [SW-1:0] RES_STATE,
   output logic          RES_MATCH,
   output logic [15:0]   RES_POS,
   output logic [SW-1:0] STATE,
   output logic          ERR
);
   localparam int HW = $clog2(NENT + 1);
   typedef enum logic [2:0] {IDLE, G_RD, G_CMP, F_RD, F_CAP, O_RD, O_CAP, DONE} st_t;
   st_t st, st_n;
   logic [CW-1:0] ch;
   logic [AW-1:0] i;
   logic [HW-1:0] hop;
   logic [15:0] pos;
   logic sel_q;
   logic [TW-1:0] addr_q;
   logic hit, tbl_end, hop_last;
   assign hit = TBL_CUR == STATE && TBL_CHR == ch;
   assign tbl_end = TBL_CUR == {SW{1'b1}} || i == AW'(NENT - 1);
   assign hop_last = hop == HW'(NENT - 1);
   always_comb begin
      st_n = st;
      CH_READY = 1'b0;
      TBL_RD = 1'b0;
      TBL_SEL = sel_q;
      TBL_ADDR = addr_q;
      case (st)
         IDLE: begin
            CH_READY = EN && !FLUSH;
            st_n = (CH_VALID && CH_READY) ? G_RD : IDLE;
         end
         G_RD: begin
            TBL_RD = 1'b1;
            TBL_SEL = 1'b0;
            TBL_ADDR = TW'(i);
            st_n = G_CMP;
         end
         G_CMP: st_n = hit ? O_RD : tbl_end ? F_RD : G_RD;
         F_RD: begin
            TBL_RD = STATE != '0;
            TBL_SEL = TBL_RD ? 1'b1 : sel_q;
            TBL_ADDR = TBL_RD ? TW'(STATE) : addr_q;
            st_n = TBL_RD ? F_CAP : O_RD;
         end
         F_CAP: st_n = hop_last ? O_RD : G_RD;
         O_RD: begin
            TBL_RD = 1'b1;
            TBL_SEL = 1'b1;
            TBL_ADDR = TW'(STATE);
            st_n = O_CAP;
         end
         O_CAP: st_n = DONE;
         DONE: st_n = IDLE;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         st <= IDLE;
         STATE <= '0;
         RES_POS <= '0;
         RES_STATE <= '0;
         RES_MATCH <= 1'b0;
         RES_VALID <= 1'b0;
         ERR <= 1'b0;
         sel_q <= 1'b0;
         addr_q <= '0;
         i <= '0;
         hop <= '0;
         pos <= '0;
         ch <= '0;
      end else begin
         st <= st_n;
         RES_VALID <= st == DONE;
         if (TBL_RD) begin
            sel_q <= TBL_SEL;
            addr_q <= TBL_ADDR;
         end
         case (st)
            IDLE: begin
               if (FLUSH) begin
                  STATE <= '0;
                  RES_POS <= '0;
                  pos <= '0;
               end else if (CH_VALID && CH_READY) begin
                  ch <= CH_DATA;
                  i <= '0;
                  hop <= '0;
               end
            end
            G_CMP: begin
               if (hit) STATE <= TBL_NXT;
               else if (!tbl_end) i <= i + AW'(1);
            end
            // A runaway failure chain is cut off at NENT hops and reported as state 0.
            F_CAP: begin
               hop <= hop + HW'(1);
               i <= '0;
               STATE <= hop_last ? '0 : TBL_FAIL;
               if (hop_last) ERR <= 1'b1;
            end
            O_CAP: RES_MATCH <= TBL_OUT;
            DONE: begin
               RES_STATE <= STATE;
               RES_POS <= pos;
               pos <= pos + 16'd1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_ac_match_ctrl.sv
// tb_ac_match_ctrl: scoreboard bench for ac_match_ctrl with a registered table model.
module tb_ac_match_ctrl;
   logic       CLK = 0, RST = 1, EN = 1, FLUSH = 0, CH_VALID = 0;
   logic [3:0] CH_DATA = 0;
   logic       CH_READY, TBL_RD, TBL_SEL, RES_VALID, RES_MATCH, ERR;
   logic [7:0] TBL_ADDR, RES_STATE, STATE;
   logic [15:0] RES_POS;
   logic [7:0] TBL_CUR = 0, TBL_NXT = 0, TBL_FAIL = 0;
   logic [3:0] TBL_CHR = 0;
   logic       TBL_OUT = 0;

   ac_match_ctrl dut (
      .CLK(CLK), .RST(RST), .EN(EN), .FLUSH(FLUSH), .CH_VALID(CH_VALID), .CH_DATA(CH_DATA),
      .CH_READY(CH_READY), .TBL_RD(TBL_RD), .TBL_SEL(TBL_SEL), .TBL_ADDR(TBL_ADDR),
      .TBL_CUR(TBL_CUR), .TBL_CHR(TBL_CHR), .TBL_NXT(TBL_NXT), .TBL_FAIL(TBL_FAIL),
      .TBL_OUT(TBL_OUT), .RES_VALID(RES_VALID), .RES_STATE(RES_STATE), .RES_MATCH(RES_MATCH),
      .RES_POS(RES_POS), .STATE(STATE), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   logic [7:0] gcur[32], gnxt[32], fl[256];
   logic [3:0] gchr[32];
   logic       ol[256];
   int cyc = 0, sel_reads = 0, tests = 0, fails = 0, pos_exp = 0;

   typedef struct {int st; int m; int pos; int lat; int acc;} exp_t;
   exp_t sb[$];

   always @(posedge CLK) begin
      cyc <= cyc + 1;
      if (TBL_RD && TBL_SEL) sel_reads <= sel_reads + 1;
      if (TBL_RD && !TBL_SEL) begin
         TBL_CUR <= gcur[TBL_ADDR[4:0]];
         TBL_CHR <= gchr[TBL_ADDR[4:0]];
         TBL_NXT <= gnxt[TBL_ADDR[4:0]];
      end else if (TBL_RD) begin
         TBL_FAIL <= fl[TBL_ADDR];
         TBL_OUT <= ol[TBL_ADDR];
      end
   end

   function automatic void check(string nm, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   always @(negedge CLK) begin
      if (RES_VALID) begin
         if (sb.size() == 0) begin
            check("unexpected_result", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("res_state", RES_STATE, e.st);
            check("res_match", RES_MATCH, e.m);
            check("res_pos", RES_POS, e.pos);
            check("latency", cyc - e.acc, e.lat);
         end
      end
   end

   task automatic send(input logic [3:0] c, input int st, input int m, input int lat);
      int n = 0;
      @(negedge CLK);
      while (!CH_READY && n < 2000) begin
         @(negedge CLK);
         n++;
      end
      if (!CH_READY) check("ready_timeout", 0, 1);
      CH_VALID = 1;
      CH_DATA = c;
      @(posedge CLK);
      #1 CH_VALID = 0;
      if (st >= 0) begin
         sb.push_back('{st, m, pos_exp, lat, cyc});
         pos_exp++;
      end
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 3000) begin
         @(negedge CLK);
         n++;
      end
      check("drain", sb.size(), 0);
   endtask

   task automatic flush();
      @(negedge CLK);
      FLUSH = 1;
      CH_VALID = 1;
      CH_DATA = 4'd1;
      #1 check("ready_flush", CH_READY, 0);
      @(posedge CLK);
      #1 FLUSH = 0;
      CH_VALID = 0;
      check("flush_no_accept", TBL_RD, 0);
      check("flush_state", STATE, 0);
      check("flush_pos", RES_POS, 0);
      pos_exp = 0;
   endtask

   initial begin
      for (int k = 0; k < 32; k++) begin
         gcur[k] = 8'hFF;
         gchr[k] = 0;
         gnxt[k] = 0;
      end
      for (int k = 0; k < 256; k++) begin
         fl[k] = 0;
         ol[k] = 0;
      end
      gcur[0] = 0; gchr[0] = 1; gnxt[0] = 1;
      gcur[1] = 1; gchr[1] = 2; gnxt[1] = 2;
      gcur[2] = 0; gchr[2] = 3; gnxt[2] = 3;
      gcur[3] = 3; gchr[3] = 1; gnxt[3] = 4;
      gcur[4] = 4; gchr[4] = 2; gnxt[4] = 5;
      fl[4] = 1; fl[5] = 2;
      ol[2] = 1; ol[5] = 1;

      repeat (2) @(posedge CLK);
      #1;
      check("rst_state", STATE, 0);
      check("rst_res_valid", RES_VALID, 0);
      check("rst_res_state", RES_STATE, 0);
      check("rst_res_match", RES_MATCH, 0);
      check("rst_res_pos", RES_POS, 0);
      check("rst_err", ERR, 0);
      check("rst_tbl_rd", TBL_RD, 0);
      check("rst_tbl_sel", TBL_SEL, 0);
      check("rst_tbl_addr", TBL_ADDR, 0);
      check("rst_ready", CH_READY, 1);
      RST = 0;

      send(4'd3, 3, 0, 9);
      send(4'd1, 4, 0, 11);
      EN = 0;
      repeat (3) @(negedge CLK);
      check("ready_en_low", CH_READY, 0);
      EN = 1;
      send(4'd2, 5, 1, 13);
      drain();

      flush();
      send(4'd1, 1, 0, 5);
      send(4'd1, 1, 0, 19);
      drain();

      flush();
      begin
         int r0;
         r0 = sel_reads;
         send(4'd5, 0, 0, 16);
         drain();
         check("no_fail_read", sel_reads - r0, 1);
      end

      send(4'd1, 1, 0, 5);
      send(4'd2, -1, 0, 0);
      @(posedge CLK);
      #1 RST = 1;
      @(posedge CLK);
      #1 RST = 0;
      check("abort_state", STATE, 0);
      check("abort_pos", RES_POS, 0);
      check("abort_valid", RES_VALID, 0);
      repeat (30) @(negedge CLK);
      check("abort_sb", sb.size(), 0);

      pos_exp = 0;
      fl[1] = 1;
      send(4'd1, 1, 0, 5);
      send(4'd4, 0, 0, 451);
      drain();
      @(negedge CLK);
      check("loop_err", ERR, 1);
      check("loop_state", STATE, 0);
      check("loop_ready", CH_READY, 1);
      RST = 1;
      @(posedge CLK);
      #1 RST = 0;
      check("err_cleared", ERR, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
